// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO round-robin arbiter.
// State encodings, default thresholds and destination-width helper.
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } arb_state_t;

  localparam int NUM_Q_DEF     = 4;
  localparam int WORD_SIZE_DEF = 6;
  localparam int PTR_L_DEF     = 3;
  localparam int MEM_SIZE_DEF  = 4;
  localparam int EMPTY_THR_DEF = 1;

  function automatic int dest_bits(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// Combinational round-robin priority encoder: first requester at or above
// i_ptr, wrapping from NUM_Q-1 back to 0.
module rr_grant #(
  parameter int NUM_Q  = 4,
  parameter int DEST_L = 2
) (
  input  logic [NUM_Q-1:0]  i_req,
  input  logic [DEST_L-1:0] i_ptr,
  output logic [NUM_Q-1:0]  o_grant,
  output logic [DEST_L-1:0] o_grant_idx,
  output logic              o_any_grant
);

  logic [DEST_L-1:0] w_q;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_q         = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      // NUM_Q is a power of two, so the DEST_L-bit add wraps naturally.
      w_q = i_ptr + DEST_L'(i);
      if (!o_any_grant && i_req[w_q]) begin
        o_any_grant  = 1'b1;
        o_grant_idx  = w_q;
        o_grant[w_q] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler from NUM_Q input FIFOs to NUM_Q output FIFOs with
// latched thresholds. Optional per-output push counters: ARB_STATS_EN.
// Handshake: in_pop[g] high for one cycle pops input g; the head word seen
// that cycle is pushed (out_push[dest], out_data) in the next cycle.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_Q     = NUM_Q_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int PTR_L     = PTR_L_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF,
  parameter int DEST_L    = dest_bits(NUM_Q)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [PTR_L-1:0]           empty_thr_in,
  input  logic [PTR_L-1:0]           full_thr_in,
  input  logic [NUM_Q-1:0]           in_empty,
  input  logic [NUM_Q*WORD_SIZE-1:0] in_data,
  input  logic [NUM_Q-1:0]           out_almost_full,
  input  logic [NUM_Q-1:0]           out_full,
  output logic [NUM_Q-1:0]           in_pop,
  output logic [NUM_Q-1:0]           out_push,
  output logic [WORD_SIZE-1:0]       out_data,
  output logic [PTR_L-1:0]           empty_threshold,
  output logic [PTR_L-1:0]           full_threshold,
  output logic [2:0]                 state,
  output logic                       idle,
  output logic                       error
`ifdef ARB_STATS_EN
  ,output logic [NUM_Q*8-1:0]        push_count
`endif
);

  arb_state_t         r_state, w_state_nx;
  logic [DEST_L-1:0]  r_ptr, w_ptr_nx;
  logic [NUM_Q-1:0]   r_in_pop, w_in_pop_nx;
  logic [DEST_L-1:0]  r_pop_idx, w_pop_idx_nx;
  logic [NUM_Q-1:0]   r_out_push, w_out_push_nx;
  logic [WORD_SIZE-1:0] r_out_data, w_out_data_nx;
  logic [PTR_L-1:0]   r_empty_thr, w_empty_thr_nx;
  logic [PTR_L-1:0]   r_full_thr, w_full_thr_nx;

  logic [NUM_Q-1:0]     w_grant;
  logic [DEST_L-1:0]    w_gidx;
  logic                 w_any;
  logic [WORD_SIZE-1:0] w_word;
  logic [DEST_L-1:0]    w_dest;
  logic [NUM_Q-1:0]     w_dest_oh;
  logic                 w_pending;
  logic                 w_overflow;
  logic                 w_grant_ok;

  rr_grant #(.NUM_Q(NUM_Q), .DEST_L(DEST_L)) u_rr_grant (
    .i_req       (~in_empty),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any_grant (w_any)
  );

  // Word being popped this cycle and its destination.
  always_comb begin
    w_word    = '0;
    w_dest_oh = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      if (r_pop_idx == DEST_L'(q)) w_word = in_data[q*WORD_SIZE +: WORD_SIZE];
    end
    w_dest = w_word[WORD_SIZE-1 -: DEST_L];
    for (int q = 0; q < NUM_Q; q++) begin
      w_dest_oh[q] = (w_dest == DEST_L'(q));
    end
  end

  assign w_pending  = |r_in_pop;
  assign w_overflow = w_pending && out_full[w_dest] && (r_state != S_RESET);
  assign w_grant_ok = (r_state == S_ACTIVE) && !init && !w_overflow &&
                      (out_almost_full == '0) && w_any;

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_in_pop_nx    = '0;
    w_pop_idx_nx   = r_pop_idx;
    w_out_push_nx  = '0;
    w_out_data_nx  = r_out_data;
    w_empty_thr_nx = r_empty_thr;
    w_full_thr_nx  = r_full_thr;

    if (w_pending && r_state != S_ERROR && !w_overflow) begin
      w_out_push_nx = w_dest_oh;
      w_out_data_nx = w_word;
    end

    if (w_grant_ok) begin
      w_in_pop_nx  = w_grant;
      w_pop_idx_nx = w_gidx;
      w_ptr_nx     = w_gidx + DEST_L'(1);
    end

    case (r_state)
      S_RESET:  w_state_nx = S_INIT;
      S_INIT: begin
        w_empty_thr_nx = empty_thr_in;
        w_full_thr_nx  = full_thr_in;
        if (!init) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (init)                 w_state_nx = S_INIT;
        else if (~in_empty != '0) w_state_nx = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                          w_state_nx = S_INIT;
        else if (&in_empty && !w_pending)  w_state_nx = S_IDLE;
      end
      S_ERROR:  w_state_nx = S_ERROR;
      default:  w_state_nx = S_ERROR;
    endcase

    if (w_overflow) w_state_nx = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RESET;
      r_ptr       <= '0;
      r_in_pop    <= '0;
      r_pop_idx   <= '0;
      r_out_push  <= '0;
      r_out_data  <= '0;
      r_empty_thr <= PTR_L'(EMPTY_THR_DEF);
      r_full_thr  <= PTR_L'(MEM_SIZE - 1);
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_in_pop    <= w_in_pop_nx;
      r_pop_idx   <= w_pop_idx_nx;
      r_out_push  <= w_out_push_nx;
      r_out_data  <= w_out_data_nx;
      r_empty_thr <= w_empty_thr_nx;
      r_full_thr  <= w_full_thr_nx;
    end
  end

  assign in_pop          = r_in_pop;
  assign out_push        = r_out_push;
  assign out_data        = r_out_data;
  assign empty_threshold = r_empty_thr;
  assign full_threshold  = r_full_thr;
  assign state           = r_state;
  assign idle            = (r_state == S_IDLE);
  assign error           = (r_state == S_ERROR);

`ifdef ARB_STATS_EN
  logic [NUM_Q*8-1:0] r_push_count;

  // Per-output push counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push_count <= '0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        if (r_out_push[q] && r_push_count[q*8 +: 8] != 8'hFF)
          r_push_count[q*8 +: 8] <= r_push_count[q*8 +: 8] + 8'd1;
      end
    end
  end

  assign push_count = r_push_count;
`endif

endmodule
